div_seq_32bit: RTL and testbench



---
 rtl/div_pkg.sv | 14 +
 rtl/div_step.sv | 28 ++
 rtl/div_seq_32bit.sv | 165 ++++++++++++++++
 tb/tb_div_seq_32bit.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the sequential divider
package div_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int DIV_CNT_W = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        CALC  = 2'd2,
        DONE  = 2'd3
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division step
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] i_rem,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH-1:0] o_rem,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] w_shift_lo;
    logic [WIDTH-1:0] w_diff;
    logic             w_ge;

    assign w_shift_lo = {i_rem[WIDTH-2:0], i_q[WIDTH-1]};
    // The bit shifted out of rem is the WIDTH-th bit of the trial value; if set,
    // the trial value already exceeds any WIDTH-bit divisor and the low bits of
    // the difference are exact because the result is below the divisor.
    assign w_ge   = i_rem[WIDTH-1] | (w_shift_lo >= i_divisor);
    assign w_diff = w_shift_lo - i_divisor;

    assign o_rem = w_ge ? w_diff : w_shift_lo;
    assign o_q   = {i_q[WIDTH-2:0], w_ge};

endmodule

// File: rtl/div_seq_32bit.sv
// rtl/div_seq_32bit.sv - iterative restoring divider with valid/ready handshake
// Optional signed truncating division when DIV_SEQ_SIGNED_EN is defined.
module div_seq_32bit
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef DIV_SEQ_SIGNED_EN
    input  logic             is_signed,
`endif
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CNT_W = $clog2(WIDTH);

    div_state_t       r_state;
    div_state_t       w_next_state;
    logic             r_in_ready;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_q;
    logic [CNT_W-1:0] r_cnt;
    logic             r_dbz;
    logic             w_accept;
    logic             w_out_valid;
    logic             w_div_zero;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_step_rem;
    logic [WIDTH-1:0] w_step_q;

`ifdef DIV_SEQ_SIGNED_EN
    logic r_is_signed;
    logic r_neg_q;
    logic r_neg_r;
    logic r_fix_pend;

    assign w_mag_a     = (r_is_signed && r_dividend[WIDTH-1]) ? (-r_dividend) : r_dividend;
    assign w_mag_b     = (r_is_signed && r_divisor[WIDTH-1])  ? (-r_divisor)  : r_divisor;
    assign w_out_valid = (r_state == DONE) && !r_fix_pend;
`else
    assign w_mag_a     = r_dividend;
    assign w_mag_b     = r_divisor;
    assign w_out_valid = (r_state == DONE);
`endif

    assign w_accept   = in_valid && r_in_ready;
    assign w_div_zero = (r_divisor == '0);

    div_step #(
        .WIDTH(WIDTH)
    ) u_step (
        .i_rem    (r_rem),
        .i_q      (r_q),
        .i_divisor(r_divisor),
        .o_rem    (w_step_rem),
        .o_q      (w_step_q)
    );

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next_state = SETUP;
            SETUP:   w_next_state = w_div_zero ? DONE : CALC;
            CALC:    if (r_cnt == '0) w_next_state = DONE;
            DONE:    if (w_out_valid && out_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // in_ready is registered so it stays low during reset and rises on the first edge after
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_next_state;
            r_in_ready <= (w_next_state == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dividend <= '0;
            r_divisor  <= '0;
            r_rem      <= '0;
            r_q        <= '0;
            r_cnt      <= '0;
            r_dbz      <= 1'b0;
`ifdef DIV_SEQ_SIGNED_EN
            r_is_signed <= 1'b0;
            r_neg_q     <= 1'b0;
            r_neg_r     <= 1'b0;
            r_fix_pend  <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_dividend <= dividend;
                        r_divisor  <= divisor;
`ifdef DIV_SEQ_SIGNED_EN
                        r_is_signed <= is_signed;
`endif
                    end
                end
                SETUP: begin
                    if (w_div_zero) begin
                        r_q   <= '0;
                        r_rem <= r_dividend;
                        r_dbz <= 1'b1;
`ifdef DIV_SEQ_SIGNED_EN
                        r_fix_pend <= 1'b0;
`endif
                    end else begin
                        r_q       <= w_mag_a;
                        r_rem     <= '0;
                        r_divisor <= w_mag_b;
                        r_cnt     <= CNT_W'(WIDTH - 1);
                        r_dbz     <= 1'b0;
`ifdef DIV_SEQ_SIGNED_EN
                        r_neg_q    <= r_is_signed && (r_dividend[WIDTH-1] ^ r_divisor[WIDTH-1]);
                        r_neg_r    <= r_is_signed && r_dividend[WIDTH-1];
                        r_fix_pend <= 1'b1;
`endif
                    end
                end
                CALC: begin
                    r_rem <= w_step_rem;
                    r_q   <= w_step_q;
                    r_cnt <= r_cnt - 1'b1;
                end
                DONE: begin
`ifdef DIV_SEQ_SIGNED_EN
                    // Magnitude results become signed here, one cycle before out_valid
                    if (r_fix_pend) begin
                        r_q        <= r_neg_q ? (-r_q) : r_q;
                        r_rem      <= r_neg_r ? (-r_rem) : r_rem;
                        r_fix_pend <= 1'b0;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = w_out_valid;
    assign quotient    = r_q;
    assign remainder   = r_rem;
    assign div_by_zero = r_dbz;

endmodule

// File: tb/tb_div_seq_32bit.sv
// tb/tb_div_seq_32bit.sv - directed self-checking bench for div_seq_32bit
module tb_div_seq_32bit;

    localparam int W = 32;
`ifdef DIV_SEQ_SIGNED_EN
    localparam int LAT = W + 3;
`else
    localparam int LAT = W + 2;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
`ifdef DIV_SEQ_SIGNED_EN
    logic         is_signed = 1'b0;
`endif

    int n_total = 0;
    int n_bad = 0;

    div_seq_32bit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
`ifdef DIV_SEQ_SIGNED_EN
        .is_signed  (is_signed),
`endif
        .dividend   (dividend),
        .divisor    (divisor),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] eq, input logic [W-1:0] er,
                          input logic edbz, input int elat, input int hold, input bit pulse);
        int cyc;
        int guard;
        int unstable;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("ready_before", W'(in_ready), 1);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = $urandom;
        divisor  = $urandom;
        cyc = 0;
        chk("ready_after_accept", W'(in_ready), 0);
        while (!out_valid && cyc < 200) begin
            if (pulse && cyc == 5) begin
                in_valid = 1'b1;
                dividend = 9;
                divisor  = 2;
            end else begin
                in_valid = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        chk("latency", W'(cyc + 1), W'(elat));
        chk("quotient", quotient, eq);
        chk("remainder", remainder, er);
        chk("div_by_zero", W'(div_by_zero), W'(edbz));
        chk("ready_in_done", W'(in_ready), 0);
        unstable = 0;
        repeat (hold) begin
            @(posedge clk); #1;
            if (!out_valid || in_ready || quotient !== eq || remainder !== er) unstable++;
        end
        if (hold > 0) chk("backpressure_stable", W'(unstable), 0);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("valid_cleared", W'(out_valid), 0);
        chk("ready_after_done", W'(in_ready), 1);
        chk("quotient_held", quotient, eq);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", W'(in_ready), 0);
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_quotient", quotient, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_dbz", W'(div_by_zero), 0);
        rst_n = 1'b1;
        #1;
        chk("ready_low_until_edge", W'(in_ready), 0);
        @(posedge clk); #1;
        chk("ready_first_edge", W'(in_ready), 1);

        do_div(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, LAT, 10, 1'b1);
        do_div(32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, LAT, 0, 1'b0);
        do_div(32'd5, 32'hFFFF_FFFF, 32'd0, 32'd5, 1'b0, LAT, 0, 1'b0);
        do_div(32'd1234, 32'd0, 32'd0, 32'd1234, 1'b1, 2, 3, 1'b0);
        do_div(32'd7, 32'd7, 32'd1, 32'd0, 1'b0, LAT, 0, 1'b0);
        do_div(32'd0, 32'd5, 32'd0, 32'd0, 1'b0, LAT, 0, 1'b0);
        do_div(32'hDEAD_BEEF, 32'h0001_0000, 32'h0000_DEAD, 32'h0000_BEEF, 1'b0, LAT, 0, 1'b0);

        dividend = 32'd40;
        divisor  = 32'd3;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (11) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        chk("abort_out_valid", W'(out_valid), 0);
        chk("abort_in_ready", W'(in_ready), 0);
        chk("abort_quotient", quotient, 0);
        chk("abort_remainder", remainder, 0);
        chk("abort_dbz", W'(div_by_zero), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready_back", W'(in_ready), 1);
        do_div(32'd40, 32'd3, 32'd13, 32'd1, 1'b0, LAT, 0, 1'b0);

`ifdef DIV_SEQ_SIGNED_EN
        is_signed = 1'b1;
        do_div(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT, 0, 1'b0);
        do_div(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0, LAT, 0, 1'b0);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0, 35, 0, 1'b0);
        do_div(32'hFFFF_FFF9, 32'd0, 32'd0, 32'hFFFF_FFF9, 1'b1, 2, 0, 1'b0);
        is_signed = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
